// File: rtl/xintf_pkg.sv
// xintf_pkg: shared state encoding, default timing and FPGA register map for the XINTF master
package xintf_pkg;
  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TRAIL} state_e;
  localparam int LEAD_CYC_DEF = 2;
  localparam int ACTIVE_CYC_DEF = 4;
  localparam int TRAIL_CYC_DEF = 2;
  localparam logic [3:0] CMD_ADDR = 4'h0;
  localparam logic [3:0] STAT_ADDR = 4'h1;
  // Phase counters count down to zero, so a phase of n cycles loads n-1
  function automatic logic [3:0] cnt_load(input int n);
    return 4'(n - 1);
  endfunction
endpackage

// File: rtl/xintf_sync_edge.sv
// xintf_sync_edge: two-flop synchroniser followed by a rising-edge detector
module xintf_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);
  logic [2:0] sh_q;
  // sh_q[1:0] synchronise, sh_q[2] remembers the previous synchronised level
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sh_q <= '0;
    else sh_q <= {sh_q[1:0], d_i};
  assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/xintf_master.sv
// xintf_master: XINTF zone-7 bus master with user transfers and interrupt-driven status reads
module xintf_master
  import xintf_pkg::*;
#(
  parameter int         LEAD_CYC    = LEAD_CYC_DEF,
  parameter int         ACTIVE_CYC  = ACTIVE_CYC_DEF,
  parameter int         TRAIL_CYC   = TRAIL_CYC_DEF,
  parameter logic [3:0] STATUS_ADDR = STAT_ADDR
) (
  input  logic       CLK0,
  input  logic       RSTn,
  input  logic       REQ,
  input  logic       REQ_WR,
  input  logic [3:0] REQ_ADDR,
  input  logic [7:0] REQ_WDATA,
  output logic       READY,
  output logic       DONE,
  output logic [7:0] RDATA,
  input  logic       INT1,
  output logic [6:0] STATUS,
  output logic       STATUS_VALID,
  output logic [3:0] XA,
  output logic       XZCS7n,
  output logic       XRDn,
  output logic       XWE0n,
  output logic [7:0] XD_O,
  output logic       XD_OE,
  input  logic [7:0] XD_I
);
  state_e     state_q;
  logic [3:0] cnt_q, xa_q;
  logic       wr_q, irq_q, int_pend_q, ready_q, done_q, stat_v_q;
  logic       cs_n_q, rd_n_q, we_n_q, oe_q;
  logic [7:0] xdo_q, cap_q, rdata_q;
  logic [6:0] status_q;
  logic       int_rise, launch_irq, launch_usr, last, int_pend_d, ready_d;

  xintf_sync_edge u_int1_sync (
    .clk_i (CLK0),
    .rst_ni(RSTn),
    .d_i   (INT1),
    .rise_o(int_rise)
  );

  // A pending interrupt wins in IDLE; a user request only goes when READY was already high
  assign launch_irq = (state_q == IDLE) && int_pend_q;
  assign launch_usr = (state_q == IDLE) && !int_pend_q && ready_q && REQ;
  assign last       = (cnt_q == 4'd0);
  // A new edge always re-arms the pending flag, even while the status read launches
  assign int_pend_d = int_rise | (int_pend_q & ~launch_irq);
  assign ready_d    = ((state_q == IDLE && !launch_irq && !launch_usr) ||
                       (state_q == TRAIL && last)) && !int_pend_d;

  // Transfer sequencer with all bus and user outputs registered
  always_ff @(posedge CLK0 or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      xa_q       <= '0;
      wr_q       <= 1'b0;
      irq_q      <= 1'b0;
      int_pend_q <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      stat_v_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      xdo_q      <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
    end else begin
      int_pend_q <= int_pend_d;
      ready_q    <= ready_d;
      done_q     <= 1'b0;
      stat_v_q   <= 1'b0;
      case (state_q)
        IDLE:
          if (launch_irq || launch_usr) begin
            state_q <= LEAD;
            cnt_q   <= cnt_load(LEAD_CYC);
            cs_n_q  <= 1'b0;
            irq_q   <= launch_irq;
            wr_q    <= launch_usr && REQ_WR;
            oe_q    <= launch_usr && REQ_WR;
            xa_q    <= launch_irq ? STATUS_ADDR : REQ_ADDR;
            if (launch_usr && REQ_WR) xdo_q <= REQ_WDATA;
          end
        LEAD:
          if (last) begin
            state_q <= ACTIVE;
            cnt_q   <= cnt_load(ACTIVE_CYC);
            rd_n_q  <= wr_q;
            we_n_q  <= !wr_q;
          end else cnt_q <= cnt_q - 4'd1;
        ACTIVE:
          if (last) begin
            state_q <= TRAIL;
            cnt_q   <= cnt_load(TRAIL_CYC);
            rd_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            cap_q   <= XD_I;
          end else cnt_q <= cnt_q - 4'd1;
        TRAIL:
          if (last) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            if (irq_q) begin
              status_q <= cap_q[6:0];
              stat_v_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
              if (!wr_q) rdata_q <= cap_q;
            end
          end else cnt_q <= cnt_q - 4'd1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign READY        = ready_q;
  assign DONE         = done_q;
  assign RDATA        = rdata_q;
  assign STATUS       = status_q;
  assign STATUS_VALID = stat_v_q;
  assign XA           = xa_q;
  assign XZCS7n       = cs_n_q;
  assign XRDn         = rd_n_q;
  assign XWE0n        = we_n_q;
  assign XD_O         = xdo_q;
  assign XD_OE        = oe_q;
endmodule

// File: tb/tb_xintf_master.sv
// tb_xintf_master: directed table-driven checks of the XINTF master plus interrupt/reset sequences
module tb_xintf_master;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic req = 1'b0, wr = 1'b0, int1 = 1'b0, int2 = 1'b0, sel = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wd = '0, model = '0;
  logic req1, req2;
  assign req1 = req & ~sel;
  assign req2 = req & sel;

  logic rdy1, done1, sv1, cs1, rd1, we1, oe1, rdy2, done2, sv2, cs2, rd2, we2, oe2;
  logic [3:0] xa1, xa2;
  logic [7:0] xdo1, xdo2, rdata1, rdata2, xdi1, xdi2;
  logic [6:0] st1, st2;
  assign xdi1 = rd1 ? 8'h00 : model;
  assign xdi2 = rd2 ? 8'h00 : model;

  xintf_master dut1 (
    .CLK0(clk), .RSTn(rstn), .REQ(req1), .REQ_WR(wr), .REQ_ADDR(addr), .REQ_WDATA(wd),
    .READY(rdy1), .DONE(done1), .RDATA(rdata1), .INT1(int1), .STATUS(st1), .STATUS_VALID(sv1),
    .XA(xa1), .XZCS7n(cs1), .XRDn(rd1), .XWE0n(we1), .XD_O(xdo1), .XD_OE(oe1), .XD_I(xdi1)
  );

  xintf_master #(.LEAD_CYC(1), .ACTIVE_CYC(1), .TRAIL_CYC(1)) dut2 (
    .CLK0(clk), .RSTn(rstn), .REQ(req2), .REQ_WR(wr), .REQ_ADDR(addr), .REQ_WDATA(wd),
    .READY(rdy2), .DONE(done2), .RDATA(rdata2), .INT1(int2), .STATUS(st2), .STATUS_VALID(sv2),
    .XA(xa2), .XZCS7n(cs2), .XRDn(rd2), .XWE0n(we2), .XD_O(xdo2), .XD_OE(oe2), .XD_I(xdi2)
  );

  logic m_cs, m_rd, m_we, m_oe, m_rdy, m_done, m_sv;
  logic [3:0] m_xa;
  logic [7:0] m_xdo, m_rdata;
  assign m_cs    = sel ? cs2 : cs1;
  assign m_rd    = sel ? rd2 : rd1;
  assign m_we    = sel ? we2 : we1;
  assign m_oe    = sel ? oe2 : oe1;
  assign m_rdy   = sel ? rdy2 : rdy1;
  assign m_done  = sel ? done2 : done1;
  assign m_sv    = sel ? sv2 : sv1;
  assign m_xa    = sel ? xa2 : xa1;
  assign m_xdo   = sel ? xdo2 : xdo1;
  assign m_rdata = sel ? rdata2 : rdata1;

  int n_cmp = 0, n_bad = 0;
  int cs_n, stb_f, stb_n, oth_n, oe_err, xa_err, done_n, done_at, sv_n, sv_at, rdy_n;
  logic [7:0] rd_at_done;

  typedef struct {
    logic sel; logic wr; logic [3:0] addr; logic [7:0] wd; logic [7:0] xdi;
    int cs; int sf; int sn; int dat; logic [7:0] rdata;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Samples n cycles at the falling edge; cycle 1 is the first cycle after the accepting edge
  task automatic watch(input int n, input logic w, input logic [3:0] a, input logic [7:0] d);
    cs_n = 0; stb_f = 0; stb_n = 0; oth_n = 0; oe_err = 0; xa_err = 0;
    done_n = 0; done_at = 0; sv_n = 0; sv_at = 0; rdy_n = 0; rd_at_done = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (!m_cs) begin
        cs_n++;
        if (m_xa != a) xa_err++;
        if (w ? (!m_oe || m_xdo != d) : m_oe) oe_err++;
      end else if (m_oe) oe_err++;
      if (!(w ? m_we : m_rd)) begin
        if (stb_n == 0) stb_f = i;
        stb_n++;
      end
      if (!(w ? m_rd : m_we)) oth_n++;
      if (m_done) begin done_n++; done_at = i; rd_at_done = m_rdata; end
      if (m_sv) begin if (sv_n == 0) sv_at = i; sv_n++; end
      if (m_rdy && sv_n == 0) rdy_n++;
    end
  endtask

  task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d);
    int k = 0;
    while (!m_rdy && k < 20) begin @(negedge clk); k++; end
    if (!m_rdy) chk("ready_wait", 0, 1);
    wr = w; addr = a; wd = d; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    tv[0] = '{1'b0, 1'b1, 4'h0, 8'h05, 8'h00, 8, 3, 4, 9, 8'h00};
    tv[1] = '{1'b0, 1'b0, 4'h1, 8'h00, 8'h5A, 8, 3, 4, 9, 8'h5A};
    tv[2] = '{1'b0, 1'b1, 4'hF, 8'hA5, 8'h00, 8, 3, 4, 9, 8'h5A};
    tv[3] = '{1'b0, 1'b0, 4'h3, 8'h00, 8'hC3, 8, 3, 4, 9, 8'hC3};
    tv[4] = '{1'b0, 1'b1, 4'h7, 8'hFF, 8'h00, 8, 3, 4, 9, 8'hC3};
    tv[5] = '{1'b1, 1'b0, 4'h5, 8'h00, 8'h96, 3, 2, 1, 4, 8'h96};
    tv[6] = '{1'b1, 1'b1, 4'h9, 8'h3C, 8'h00, 3, 2, 1, 4, 8'h96};
    tv[7] = '{1'b1, 1'b0, 4'h2, 8'h00, 8'h71, 3, 2, 1, 4, 8'h71};

    repeat (3) @(negedge clk);
    chk("rst_bus", {cs1, rd1, we1, oe1}, 4'b1110);
    chk("rst_xa_xdo", {xa1, xdo1}, 0);
    chk("rst_user", {rdata1, 1'b0, st1, done1, sv1, rdy1}, 0);
    rstn = 1'b1;
    #1 chk("rel_ready_c1", rdy1, 0);
    @(posedge clk);
    #1 chk("rel_ready_c2", rdy1, 1);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      sel = tv[i].sel; model = tv[i].xdi;
      issue(tv[i].wr, tv[i].addr, tv[i].wd);
      watch(tv[i].dat + 2, tv[i].wr, tv[i].addr, tv[i].wd);
      chk($sformatf("v%0d_cs_len", i), cs_n, tv[i].cs);
      chk($sformatf("v%0d_stb_first", i), stb_f, tv[i].sf);
      chk($sformatf("v%0d_stb_len", i), stb_n, tv[i].sn);
      chk($sformatf("v%0d_other_stb", i), oth_n, 0);
      chk($sformatf("v%0d_oe_data", i), oe_err, 0);
      chk($sformatf("v%0d_xa", i), xa_err, 0);
      chk($sformatf("v%0d_done_n", i), done_n, 1);
      chk($sformatf("v%0d_done_at", i), done_at, tv[i].dat);
      chk($sformatf("v%0d_rdata", i), rd_at_done, tv[i].rdata);
      chk($sformatf("v%0d_sv_n", i), sv_n, 0);
    end
    sel = 1'b0;

    model = 8'h2B; int1 = 1'b1;
    watch(20, 1'b0, 4'h1, 8'h00);
    chk("irq_cs_len", cs_n, 8);
    chk("irq_stb_len", stb_n, 4);
    chk("irq_xa", xa_err, 0);
    chk("irq_oe", oe_err, 0);
    chk("irq_sv_n", sv_n, 1);
    chk("irq_done_n", done_n, 0);
    chk("irq_status", st1, 'h2B);
    chk("irq_rdata_kept", rdata1, 'hC3);
    int1 = 1'b0;
    watch(10, 1'b0, 4'h1, 8'h00);
    chk("irq_fall_no_read", cs_n, 0);

    model = 8'h55;
    fork
      watch(40, 1'b0, 4'h1, 8'h00);
      begin
        int1 = 1'b1;
        repeat (6) @(negedge clk);
        int1 = 1'b0;
        repeat (3) @(negedge clk);
        int1 = 1'b1;
      end
    join
    chk("irq2_sv_n", sv_n, 2);
    chk("irq2_cs_len", cs_n, 16);
    chk("irq2_status", st1, 'h55);
    int1 = 1'b0;
    repeat (5) @(negedge clk);

    model = 8'h17; int1 = 1'b1;
    repeat (2) @(negedge clk);
    wr = 1'b1; addr = 4'h2; wd = 8'hE7; req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    watch(25, 1'b1, 4'h2, 8'hE7);
    chk("col_done_at", done_at, 9);
    chk("col_done_n", done_n, 1);
    chk("col_sv_at", sv_at, 18);
    chk("col_sv_n", sv_n, 1);
    chk("col_cs_len", cs_n, 16);
    chk("col_ready_low", rdy_n, 0);
    chk("col_ready_after", m_rdy, 1);
    chk("col_status", st1, 'h17);
    int1 = 1'b0;
    repeat (5) @(negedge clk);

    issue(1'b1, 4'h6, 8'h81);
    repeat (4) @(negedge clk);
    chk("rst_mid_active_we", we1, 0);
    #2 rstn = 1'b0;
    #1 chk("rst_mid_bus", {cs1, rd1, we1, oe1}, 4'b1110);
    chk("rst_mid_xa_xdo", {xa1, xdo1}, 0);
    chk("rst_mid_user", {done1, sv1, rdy1}, 0);
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("rst_mid_ready_c1", rdy1, 0);
    @(posedge clk);
    #1 chk("rst_mid_ready_c2", rdy1, 1);
    watch(10, 1'b1, 4'h6, 8'h81);
    chk("rst_mid_no_done", done_n, 0);
    chk("rst_mid_no_cs", cs_n, 0);
    chk("rst_mid_rdata", rdata1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
